addr_gen_bp_seq: RTL

//  Parametrised read/write address sequencer for LSTM backprop buffers (dstate, dout, dgates).

---
 rtl/addr_gen_bp_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/addr_gen_bp_seq.sv
// rtl/addr_gen_bp_seq.sv - paired rd/wr circular address sequencer for LSTM backprop buffers.
// Optional ADDR_GEN_REVERSE_EN adds i_reverse to step both pointers downward for a run.
module addr_gen_bp_seq #(
   parameter int ADDR_WIDTH   = 12,
   parameter int NUM_CELL     = 8,
   parameter int DEPTH        = 2,
   parameter int WR_OFFSET    = 8,
   parameter int HOLD         = 12,
   parameter int DELAY        = 12,
   parameter int NUM_TIMESTEP = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_en,
`ifdef ADDR_GEN_REVERSE_EN
   input  logic                  i_reverse,
`endif
   output logic [ADDR_WIDTH-1:0] o_addr_rd,
   output logic [ADDR_WIDTH-1:0] o_addr_wr,
   output logic                  o_addr_stb,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int WRAP = NUM_CELL * DEPTH;
   localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int CW   = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
   localparam int GW   = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam int SW   = (NUM_TIMESTEP > 1) ? $clog2(NUM_TIMESTEP) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [HW-1:0]         cnt_hold_q, cnt_hold_d;
   logic [CW-1:0]         cnt_cell_q, cnt_cell_d;
   logic [GW-1:0]         cnt_gap_q, cnt_gap_d;
   logic [SW-1:0]         cnt_step_q, cnt_step_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic [ADDR_WIDTH-1:0] wr_q, wr_d;
   logic                  stb_q, stb_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  rev_q, rev_d;
   logic                  rev_start;

`ifdef ADDR_GEN_REVERSE_EN
   assign rev_start = i_reverse;
`else
   assign rev_start = 1'b0;
`endif

   // rd and wr wrap independently at WRAP, which need not be a power of two
   function automatic logic [ADDR_WIDTH-1:0] step_ptr(input logic [ADDR_WIDTH-1:0] p,
                                                      input logic dn);
      if (dn)
         step_ptr = (p == '0) ? ADDR_WIDTH'(WRAP - 1) : p - 1'b1;
      else
         step_ptr = (p == ADDR_WIDTH'(WRAP - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_hold_d = cnt_hold_q;
      cnt_cell_d = cnt_cell_q;
      cnt_gap_d  = cnt_gap_q;
      cnt_step_d = cnt_step_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      busy_d     = busy_q;
      rev_d      = rev_q;
      stb_d      = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               rd_d       = '0;
               wr_d       = ADDR_WIDTH'(WR_OFFSET);
               cnt_hold_d = '0;
               cnt_cell_d = '0;
               cnt_gap_d  = '0;
               cnt_step_d = '0;
               rev_d      = rev_start;
               stb_d      = 1'b1;
               busy_d     = 1'b1;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (i_en) begin
               if (cnt_hold_q == HW'(HOLD - 1)) begin
                  cnt_hold_d = '0;
                  if (cnt_cell_q != CW'(NUM_CELL - 1)) begin
                     rd_d       = step_ptr(rd_q, rev_q);
                     wr_d       = step_ptr(wr_q, rev_q);
                     cnt_cell_d = cnt_cell_q + 1'b1;
                     stb_d      = 1'b1;
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  cnt_hold_d = cnt_hold_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (i_en) begin
               if (cnt_gap_q == GW'(DELAY - 1)) begin
                  cnt_gap_d  = '0;
                  cnt_cell_d = '0;
                  rd_d       = step_ptr(rd_q, rev_q);
                  wr_d       = step_ptr(wr_q, rev_q);
                  stb_d      = 1'b1;
                  if (cnt_step_q == SW'(NUM_TIMESTEP - 1)) begin
                     cnt_step_d = '0;
                     busy_d     = 1'b0;
                     done_d     = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     cnt_step_d = cnt_step_q + 1'b1;
                     state_d    = S_RUN;
                  end
               end else begin
                  cnt_gap_d = cnt_gap_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_hold_q <= '0;
         cnt_cell_q <= '0;
         cnt_gap_q  <= '0;
         cnt_step_q <= '0;
         rd_q       <= '0;
         wr_q       <= ADDR_WIDTH'(WR_OFFSET);
         stb_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rev_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_hold_q <= cnt_hold_d;
         cnt_cell_q <= cnt_cell_d;
         cnt_gap_q  <= cnt_gap_d;
         cnt_step_q <= cnt_step_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         stb_q      <= stb_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rev_q      <= rev_d;
      end
   end

   assign o_addr_rd  = rd_q;
   assign o_addr_wr  = wr_q;
   assign o_addr_stb = stb_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule
